// File: rtl/bit_cnt_feeder.sv
// rtl/bit_cnt_feeder.sv - byte FIFO that feeds an external bit counter and accumulates its results
module bit_cnt_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_full,
  output logic        o_load,
  output logic [7:0]  o_data,
  input  logic        i_ready,
  input  logic [3:0]  i_bit_cnt,
  output logic        o_res_valid,
  output logic [3:0]  o_res_cnt,
  output logic [11:0] o_total,
  output logic        o_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic            r_full;

  logic [7:0]      r_data;
  logic [3:0]      r_res_cnt;
  logic            r_res_valid;
  logic [11:0]     r_total;
  logic            r_err;
  logic [7:0]      r_tmo;
  logic            r_busy_seen;

  logic            w_pop;
  logic            w_push;
  logic            w_capture;
  logic            w_timeout;

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push = i_valid && (!r_full || w_pop);

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && i_ready) begin
          w_pop  = 1'b1;
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!i_ready) begin
          w_next = S_WAIT_DONE;
        end else if (r_busy_seen) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (i_ready) begin
          w_capture = 1'b1;
          w_next    = S_IDLE;
        end else if (r_tmo == 8'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state     <= S_IDLE;
      r_data      <= 8'd0;
      r_res_cnt   <= 4'd0;
      r_res_valid <= 1'b0;
      r_total     <= 12'd0;
      r_err       <= 1'b0;
      r_tmo       <= 8'd0;
      r_busy_seen <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_res_valid <= w_capture;
      if (w_pop) begin
        r_data <= r_mem[r_rd_ptr];
      end
      if (w_capture) begin
        r_res_cnt <= i_bit_cnt;
        r_total   <= r_total + {8'd0, i_bit_cnt};
      end
      if (w_timeout || (w_capture && (i_bit_cnt > 4'd8))) begin
        r_err <= 1'b1;
      end
      // Timeout counter restarts every time WAIT_DONE is entered.
      if ((w_next == S_WAIT_DONE) && (r_state != S_WAIT_DONE)) begin
        r_tmo <= 8'd0;
      end else if (r_state == S_WAIT_DONE) begin
        r_tmo <= r_tmo + 8'd1;
      end
      if (r_state == S_LOAD) begin
        r_busy_seen <= 1'b0;
      end else if ((r_state == S_WAIT_BUSY) && i_ready) begin
        r_busy_seen <= 1'b1;
      end
    end
  end

  assign o_full      = r_full;
  assign o_load      = (r_state == S_LOAD);
  assign o_data      = r_data;
  assign o_res_valid = r_res_valid;
  assign o_res_cnt   = r_res_cnt;
  assign o_total     = r_total;
  assign o_err       = r_err;

endmodule

// File: tb/tb_bit_cnt_feeder.sv
// tb/tb_bit_cnt_feeder.sv - directed self-checking bench for bit_cnt_feeder
module tb_bit_cnt_feeder;

  localparam int TMO = 16;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'd0;
  logic [3:0]  i_bit_cnt = 4'd0;
  logic        m_ready = 1'b1;
  logic        tb_hold = 1'b0;
  logic        w_ready;
  logic        o_full, o_load, o_res_valid, o_err;
  logic [7:0]  o_data;
  logic [3:0]  o_res_cnt;
  logic [11:0] o_total;

  int checks = 0;
  int errors = 0;
  int lat = 2;
  bit model_en = 1'b1;
  bit force_en = 1'b0;
  logic [3:0] force_val = 4'd0;
  logic [7:0] load_q[$];
  logic [3:0] res_q[$];
  int b2b = 0;
  bit prev_load = 1'b0;

  assign w_ready = m_ready & ~tb_hold;

  bit_cnt_feeder #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .iclk(iclk), .irst(irst), .i_valid(i_valid), .i_data(i_data),
    .o_full(o_full), .o_load(o_load), .o_data(o_data),
    .i_ready(w_ready), .i_bit_cnt(i_bit_cnt),
    .o_res_valid(o_res_valid), .o_res_cnt(o_res_cnt),
    .o_total(o_total), .o_err(o_err)
  );

  always #5 iclk = ~iclk;

  function automatic logic [3:0] popc(input logic [7:0] b);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 0; k < 8; k++) c = c + {3'd0, b[k]};
    return c;
  endfunction

  // Bit counter model: goes busy after a load, answers lat cycles later.
  initial begin
    logic [7:0] d;
    forever begin
      @(posedge iclk); #1;
      if (model_en && o_load) begin
        d = o_data;
        m_ready = 1'b0;
        repeat (lat) @(posedge iclk);
        #1;
        i_bit_cnt = force_en ? force_val : popc(d);
        m_ready = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge iclk); #1;
      if (o_load) begin
        load_q.push_back(o_data);
        if (prev_load) b2b++;
      end
      prev_load = o_load;
      if (o_res_valid) res_q.push_back(o_res_cnt);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iclk);
  endtask

  task automatic push_raw(input logic [7:0] d);
    @(negedge iclk);
    i_valid = 1'b1;
    i_data  = d;
    @(posedge iclk); #1;
    i_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge iclk);
    while (o_full && n < 2000) begin
      @(negedge iclk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL push_stuck o_full=%0b want 0", o_full);
    end
    i_valid = 1'b1;
    i_data  = d;
    @(posedge iclk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_res(input int base, input int n, input int budget);
    int c;
    c = 0;
    while (res_q.size() < base + n && c < budget) begin
      @(negedge iclk);
      c++;
    end
    checks++;
    if (res_q.size() < base + n) begin
      errors++;
      $display("FAIL wait_res got %0d want %0d", res_q.size() - base, n);
    end
  endtask

  task automatic wait_load(input int base);
    int c;
    c = 0;
    while (load_q.size() == base && c < 50) begin
      @(negedge iclk);
      c++;
    end
    checks++;
    if (load_q.size() == base) begin
      errors++;
      $display("FAIL wait_load got 0 want 1");
    end
  endtask

  task automatic do_reset();
    int c;
    c = 0;
    while (!m_ready && c < 100) begin
      @(negedge iclk);
      c++;
    end
    model_en = 1'b1; force_en = 1'b0; tb_hold = 1'b0; lat = 2;
    @(negedge iclk);
    irst = 1'b1; i_valid = 1'b0;
    @(negedge iclk);
    irst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({o_full, o_load, o_res_valid, o_err} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_flags got %b want 0000", tag, {o_full, o_load, o_res_valid, o_err});
    end
    checks++;
    if ({o_data, o_res_cnt, o_total} !== 24'd0) begin
      errors++;
      $display("FAIL %s_values got %h want 000000", tag, {o_data, o_res_cnt, o_total});
    end
  endtask

  task automatic test_reset();
    int lb;
    irst = 1'b1; i_valid = 1'b1; i_data = 8'hAA;
    tick(2);
    irst = 1'b0; i_valid = 1'b0;
    check_zero("reset");
    lb = load_q.size();
    tick(6);
    checks++;
    if (load_q.size() !== lb) begin
      errors++;
      $display("FAIL reset_ignore_valid loads got %0d want 0", load_q.size() - lb);
    end
  endtask

  task automatic test_single();
    int lb, rb;
    do_reset();
    lb = load_q.size(); rb = res_q.size();
    push_raw(8'h5F);
    wait_res(rb, 1, 50);
    tick(4);
    checks++;
    if (load_q.size() - lb !== 1 || load_q[lb] !== 8'h5F) begin
      errors++;
      $display("FAIL single_load got n=%0d d=%h want n=1 d=5f", load_q.size() - lb, load_q[lb]);
    end
    checks++;
    if (res_q.size() - rb !== 1 || o_res_cnt !== 4'd6) begin
      errors++;
      $display("FAIL single_res got n=%0d cnt=%0d want n=1 cnt=6", res_q.size() - rb, o_res_cnt);
    end
    checks++;
    if (o_total !== 12'd6 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL single_total got %0d err=%0b want 6 err=0", o_total, o_err);
    end
  endtask

  task automatic test_back_to_back();
    int lb, rb, b0;
    do_reset();
    lb = load_q.size(); rb = res_q.size(); b0 = b2b;
    push_raw(8'hEE); push_raw(8'hF2); push_raw(8'hCC);
    wait_res(rb, 3, 100);
    tick(4);
    checks++;
    if (load_q.size() - lb !== 3 || load_q[lb] !== 8'hEE || load_q[lb+1] !== 8'hF2 || load_q[lb+2] !== 8'hCC) begin
      errors++;
      $display("FAIL stream_loads got n=%0d want 3 in order ee f2 cc", load_q.size() - lb);
    end
    checks++;
    if (res_q.size() - rb !== 3 || res_q[rb] !== 4'd6 || res_q[rb+1] !== 4'd5 || res_q[rb+2] !== 4'd4) begin
      errors++;
      $display("FAIL stream_res got n=%0d want 3 counts 6 5 4", res_q.size() - rb);
    end
    checks++;
    if (o_total !== 12'd15 || b2b !== b0) begin
      errors++;
      $display("FAIL stream_total got %0d overlaps=%0d want 15 overlaps=0", o_total, b2b - b0);
    end
  endtask

  task automatic test_full();
    int lb, rb;
    do_reset();
    lb = load_q.size(); rb = res_q.size();
    tb_hold = 1'b1;
    push_raw(8'h01); push_raw(8'h03); push_raw(8'h07);
    checks++;
    if (o_full !== 1'b0) begin
      errors++;
      $display("FAIL full_at3 got %0b want 0", o_full);
    end
    push_raw(8'h0F);
    checks++;
    if (o_full !== 1'b1) begin
      errors++;
      $display("FAIL full_at4 got %0b want 1", o_full);
    end
    push_raw(8'hFF);
    tick(2);
    tb_hold = 1'b0;
    wait_res(rb, 4, 200);
    tick(30);
    checks++;
    if (res_q.size() - rb !== 4 || load_q.size() - lb !== 4 || load_q[lb+3] !== 8'h0F) begin
      errors++;
      $display("FAIL full_results got res=%0d loads=%0d want 4 4", res_q.size() - rb, load_q.size() - lb);
    end
    checks++;
    if (o_total !== 12'd10 || o_full !== 1'b0) begin
      errors++;
      $display("FAIL full_total got %0d full=%0b want 10 full=0", o_total, o_full);
    end
  endtask

  task automatic test_wrap();
    int rb;
    do_reset();
    rb = res_q.size();
    for (int i = 0; i < 513; i++) push(8'hFF);
    wait_res(rb, 513, 300);
    tick(4);
    checks++;
    if (o_total !== 12'd8 || res_q.size() - rb !== 513 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_total got %0d n=%0d err=%0b want 8 n=513 err=0", o_total, res_q.size() - rb, o_err);
    end
  endtask

  task automatic test_timeout();
    int lb, rb;
    do_reset();
    model_en = 1'b0;
    lb = load_q.size(); rb = res_q.size();
    push_raw(8'h3C);
    wait_load(lb);
    tb_hold = 1'b1;
    tick(TMO + 1);
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got %0b want 0", o_err);
    end
    tick(1);
    checks++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err got %0b want 1", o_err);
    end
    tick(5);
    checks++;
    if (res_q.size() !== rb || o_total !== 12'd0) begin
      errors++;
      $display("FAIL timeout_nocap got res=%0d total=%0d want 0 0", res_q.size() - rb, o_total);
    end
    tb_hold = 1'b0; model_en = 1'b1;
    push_raw(8'h0F);
    wait_res(rb, 1, 50);
    tick(2);
    checks++;
    if (o_total !== 12'd4 || o_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover got total=%0d err=%0b want 4 1", o_total, o_err);
    end
  endtask

  task automatic test_busy_timeout();
    int lb, rb;
    do_reset();
    model_en = 1'b0;
    lb = load_q.size(); rb = res_q.size();
    push_raw(8'h81);
    wait_load(lb);
    tick(6);
    checks++;
    if (o_err !== 1'b1 || res_q.size() !== rb || load_q.size() - lb !== 1 || o_total !== 12'd0) begin
      errors++;
      $display("FAIL busy_timeout got err=%0b res=%0d loads=%0d want 1 0 1", o_err, res_q.size() - rb, load_q.size() - lb);
    end
  endtask

  task automatic test_over8();
    int rb;
    do_reset();
    force_en = 1'b1; force_val = 4'd12;
    rb = res_q.size();
    push_raw(8'h01);
    wait_res(rb, 1, 50);
    tick(2);
    checks++;
    if (o_res_cnt !== 4'd12 || o_total !== 12'd12 || o_err !== 1'b1) begin
      errors++;
      $display("FAIL over8 got cnt=%0d total=%0d err=%0b want 12 12 1", o_res_cnt, o_total, o_err);
    end
    force_en = 1'b0;
  endtask

  task automatic test_midop_reset();
    int lb, rb;
    do_reset();
    lat = 12;
    lb = load_q.size(); rb = res_q.size();
    push_raw(8'h11); push_raw(8'h22); push_raw(8'h33);
    wait_load(lb);
    tick(3);
    irst = 1'b1;
    tick(1);
    irst = 1'b0;
    check_zero("midop");
    tick(30);
    checks++;
    if (load_q.size() - lb !== 1 || res_q.size() !== rb || o_total !== 12'd0) begin
      errors++;
      $display("FAIL midop_after got loads=%0d res=%0d total=%0d want 1 0 0", load_q.size() - lb, res_q.size() - rb, o_total);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_wrap();
    test_timeout();
    test_busy_timeout();
    test_over8();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_cnt_feeder.md
BIT_CNT_FEEDER -- requirements
Module: bit_cnt_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: input byte buffer depth, power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles to wait for counter completion, 2..255.
REQ-003 Clocking and reset: one clock, iclk; reset irst is synchronous and active-high.
REQ-004 iclk  input  1  clock; all logic on the rising edge.
REQ-005 irst  input  1  synchronous active-high reset.
REQ-006 i_valid  input  1  upstream byte strobe.
REQ-007 i_data  input  8  upstream byte.
REQ-008 o_full  output  1  FIFO full; upstream shall not strobe.
REQ-009 o_load  output  1  one-cycle load pulse to bit counter.
REQ-010 o_data  output  8  byte presented to bit counter; stable while o_load is high.
REQ-011 i_ready  input  1  bit counter idle / result valid.
REQ-012 i_bit_cnt  input  4  bit counter result, 0..8.
REQ-013 o_res_valid  output  1  one-cycle strobe: new per-byte result.
REQ-014 o_res_cnt  output  4  per-byte ones count, held until next strobe.
REQ-015 o_total  output  12  running sum of all captured counts.
REQ-016 o_err  output  1  sticky timeout flag.

Function
REQ-017 The FIFO shall be written on i_valid when not full; i_valid while o_full shall drop the byte and leave FIFO state unchanged.
REQ-018 o_full shall be a registered flag, high when occupancy equals FIFO_DEPTH.
REQ-019 A simultaneous write and read while full shall be treated as read-then-write: occupancy unchanged, byte accepted.
REQ-020 The FSM shall have states IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE -> LOAD when FIFO is non-empty and i_ready is 1; the FIFO head shall be popped into o_data on that edge.
REQ-022 In LOAD, o_load shall be 1 for exactly one cycle; next state is WAIT_BUSY.
REQ-023 WAIT_BUSY -> WAIT_DONE when i_ready is 0; if i_ready remains 1 for 2 consecutive cycles, WAIT_BUSY -> IDLE with no capture and o_err set.
REQ-024 WAIT_DONE -> IDLE when i_ready is 1; on that edge o_res_cnt is set to i_bit_cnt, o_res_valid pulses for one cycle, and o_total increments by i_bit_cnt.
REQ-025 The timeout counter shall reset on WAIT_DONE entry; after TIMEOUT cycles in WAIT_DONE without i_ready, the FSM shall go to IDLE, set o_err, and not capture.
REQ-026 o_total shall wrap modulo 4096 with no saturation.
REQ-027 An i_bit_cnt value above 8 at capture shall set o_err; the value shall still be captured and accumulated.
REQ-028 o_err shall clear only on irst.
REQ-029 The minimum per-byte turnaround shall be 4 cycles (IDLE, LOAD, WAIT_BUSY, WAIT_DONE) plus counter latency; the block shall never issue back-to-back o_load.
REQ-030 o_data shall change only on the IDLE -> LOAD edge.

Reset
REQ-031 irst shall set the following on the next rising edge: FSM to IDLE; FIFO empty; o_full, o_load, o_res_valid, o_err to 0; o_data, o_res_cnt, o_total to 0.
REQ-032 Reset asserted mid-transaction shall abandon the transaction and discard all buffered bytes; no o_res_valid shall follow.
REQ-033 i_valid during the irst cycle shall be ignored.

Verification
REQ-034 Single byte: push 0x5F, counter model returns 6 -> one o_load with o_data=0x5F, o_res_valid once, o_res_cnt=6, o_total=6.
REQ-035 Stream: push 0xEE, 0xF2, 0xCC back-to-back -> three loads in order; o_res_cnt=6, 5, 4; o_total=15; no overlap of o_load.
REQ-036 Full: push 5 bytes with FIFO_DEPTH=4 while i_ready is held 0 -> o_full=1 after the 4th byte, 5th byte dropped, exactly 4 results after i_ready is released.
REQ-037 Timeout: after a load, hold i_ready=0 for TIMEOUT cycles -> o_err=1, FSM returns to IDLE, no o_res_valid, o_total unchanged.
REQ-038 Wrap: 513 bytes of 0xFF with count 8 -> o_total = 4104 mod 4096 = 8.
REQ-039 Mid-op reset: assert irst in WAIT_DONE with 2 bytes queued -> all outputs 0, FIFO empty, no further loads.
